// File: rtl/gshare_pred_if.sv
// rtl/gshare_pred_if.sv - fetch, prediction and ROB retire signal bundle for gshare_pred
interface gshare_pred_if #(
  parameter int IDX_W = 14,
  parameter int CTR_W = 2
);
  logic                   fetch_bp_req;
  logic [31:2]            fetch_bp_addr;
  logic                   brpred_ready;
  logic                   brpred_valid;
  logic                   brpred_bptaken;
  logic [CTR_W+IDX_W-1:0] brpred_bptag;
  logic                   rob_flush;
  logic                   rob_ret_branch;
  logic [CTR_W+IDX_W-1:0] rob_ret_bptag;
  logic                   rob_ret_bptaken;

  modport master (
    output fetch_bp_req, fetch_bp_addr, rob_flush, rob_ret_branch, rob_ret_bptag, rob_ret_bptaken,
    input  brpred_ready, brpred_valid, brpred_bptaken, brpred_bptag
  );

  modport slave (
    input  fetch_bp_req, fetch_bp_addr, rob_flush, rob_ret_branch, rob_ret_bptag, rob_ret_bptaken,
    output brpred_ready, brpred_valid, brpred_bptaken, brpred_bptag
  );
endinterface

// File: rtl/gshare_pred.sv
// rtl/gshare_pred.sv - gshare branch direction predictor with speculative/architectural history
module gshare_pred #(
  parameter int HIST_W = 14,
  parameter int IDX_W  = 14,
  parameter int CTR_W  = 2,
  parameter int PC_LSB = 3
) (
  input logic          clk,
  input logic          rst,
  gshare_pred_if.slave bp
);
  localparam int TAG_W = CTR_W + IDX_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CTR_W-1:0]  pht_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] spec_hist_q, spec_hist_d;
  logic [HIST_W-1:0] arch_hist_q, arch_hist_d;
  logic              pend_vld_q, pend_vld_d;
  logic [CTR_W-1:0]  pend_ctr_q, pend_ctr_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic              hold_taken_q, hold_taken_d;
  logic [TAG_W-1:0]  hold_tag_q, hold_tag_d;

  logic              run;
  logic              out_valid;
  logic              pend_taken;
  logic [HIST_W-1:0] spec_fwd;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              retire;
  logic [CTR_W-1:0]  ret_ctr;
  logic [IDX_W-1:0]  ret_idx;
  logic [CTR_W-1:0]  upd_ctr;
  logic [CTR_W-1:0]  rd_ctr;
  logic              unused_addr;

  assign run        = (state_q == ST_RUN);
  // A pending response is squashed by a flush arriving in its return cycle.
  assign out_valid  = pend_vld_q & ~bp.rob_flush;
  assign pend_taken = pend_ctr_q[CTR_W-1];
  assign accept     = bp.fetch_bp_req & run & ~bp.rob_flush;
  assign retire     = bp.rob_ret_branch & run;
  assign ret_ctr    = bp.rob_ret_bptag[TAG_W-1:IDX_W];
  assign ret_idx    = bp.rob_ret_bptag[IDX_W-1:0];
  assign unused_addr = ^bp.fetch_bp_addr;

  // Forward this cycle's prediction into the history used for a back-to-back request.
  assign spec_fwd = out_valid ? HIST_W'({spec_hist_q, pend_taken}) : spec_hist_q;
  assign req_idx  = bp.fetch_bp_addr[PC_LSB+IDX_W-1:PC_LSB] ^ IDX_W'(spec_fwd);

  // Saturating counter training and write-first PHT read.
  always_comb begin
    upd_ctr = ret_ctr;
    if (bp.rob_ret_bptaken) begin
      if (ret_ctr != CTR_MAX) upd_ctr = ret_ctr + CTR_W'(1);
    end else begin
      if (ret_ctr != '0) upd_ctr = ret_ctr - CTR_W'(1);
    end
    rd_ctr = (retire && (ret_idx == req_idx)) ? upd_ctr : pht_q[req_idx];
  end

  // Next-state: sweep FSM, histories, pending request and held outputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    arch_hist_d  = arch_hist_q;
    spec_hist_d  = spec_fwd;
    pend_vld_d   = accept;
    pend_ctr_d   = pend_ctr_q;
    pend_idx_d   = pend_idx_q;
    hold_taken_d = hold_taken_q;
    hold_tag_d   = hold_tag_q;
    if (!run) begin
      ptr_d = ptr_q + IDX_W'(1);
      if (ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
    end
    if (retire) arch_hist_d = HIST_W'({arch_hist_q, bp.rob_ret_bptaken});
    if (bp.rob_flush) spec_hist_d = arch_hist_d;
    if (accept) begin
      pend_ctr_d = rd_ctr;
      pend_idx_d = req_idx;
    end
    if (out_valid) begin
      hold_taken_d = pend_taken;
      hold_tag_d   = {pend_ctr_q, pend_idx_q};
    end
  end

  // Control and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      spec_hist_q  <= '0;
      arch_hist_q  <= '0;
      pend_vld_q   <= 1'b0;
      pend_ctr_q   <= '0;
      pend_idx_q   <= '0;
      hold_taken_q <= 1'b0;
      hold_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      spec_hist_q  <= spec_hist_d;
      arch_hist_q  <= arch_hist_d;
      pend_vld_q   <= pend_vld_d;
      pend_ctr_q   <= pend_ctr_d;
      pend_idx_q   <= pend_idx_d;
      hold_taken_q <= hold_taken_d;
      hold_tag_q   <= hold_tag_d;
    end
  end

  // PHT writes: clear sweep in INIT, counter training on retire in RUN; never reset directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) pht_q[ptr_q] <= CTR_WEAK_NT;
      else if (retire) pht_q[ret_idx] <= upd_ctr;
    end
  end

  assign bp.brpred_ready   = run;
  assign bp.brpred_valid   = out_valid;
  assign bp.brpred_bptaken = out_valid ? pend_taken : hold_taken_q;
  assign bp.brpred_bptag   = out_valid ? {pend_ctr_q, pend_idx_q} : hold_tag_q;
endmodule
